uart_rx: RTL

UART serial receiver, 8N1 frame (start bit 0, 8 data bits LSB first, stop bit 1). Default timing is a 24 MHz clock at 4800 baud, i.e. 5000 clocks per bit.
Sits at the chip RX pin; it is the receive counterpart of the team's UART transmitter and uses the same frame format and bit timing.
Delivers each received byte with a one-cycle valid strobe and flags bad stop bits.

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx: serial line in, byte/status out.
interface uart_rx_if;
    logic       RX;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (input RX, output data_out, data_valid, frame_err, busy);
    modport slave (output RX, input data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, stop-bit error flag.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 5000,
    parameter int unsigned CNT_W        = 13
) (
    input  logic     clk,
    input  logic     res,
    uart_rx_if.master bus
);
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       data_q, data_n;
    logic             valid_q, valid_n;
    logic             ferr_q, ferr_n;
    logic             rx_m, rx_s, rx_d;
    logic             fall;

    // Synchroniser flops idle high so reset release never looks like a start edge
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= bus.RX;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = data_q;
        valid_n   = 1'b0;
        ferr_n    = ferr_q;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall) state_n = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets an immediately following start edge be caught
                if (cnt == BIT_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        ferr_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BRK;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            BRK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state != IDLE);
endmodule
